// File: rtl/uart_word_loader.sv
// UART download loader: parses frames (target byte, 16-bit LE word count, LE 32-bit words)
// and drives the instruction/data memory programming port.
module uart_word_loader #(
   parameter int ADDR_W  = 14,
   parameter int DEPTH   = 16384,
   parameter int TIMEOUT = 100000
) (
   input  logic              upg_clk_i,
   input  logic              upg_rst_i,
   input  logic [7:0]        rx_dat_i,
   input  logic              rx_vld_i,
   output logic              upg_wen_o,
   output logic              upg_sel_o,
   output logic [ADDR_W-1:0] upg_adr_o,
   output logic [31:0]       upg_dat_o,
   output logic              upg_done_o,
   output logic              upg_err_o,
   output logic              busy_o
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, DONE} state_t;
   state_t state, state_nxt;

   logic [7:0]    cnt_lo;
   logic [15:0]   rem;
   logic [1:0]    bidx;
   logic [23:0]   part;
   logic [TW-1:0] tcnt;

   logic        target;
   logic        in_frame;
   logic        expire;
   logic        word_end;
   logic [15:0] count;

   assign target   = rx_vld_i && (rx_dat_i[7:1] == 7'd0);
   assign in_frame = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
   assign expire   = in_frame && !rx_vld_i && (tcnt == TW'(TIMEOUT - 1));
   assign word_end = (state == DATA) && rx_vld_i && (bidx == 2'd3);
   assign count    = {rx_dat_i, cnt_lo};
   assign busy_o   = in_frame;

   // The last word moves straight to DONE so that the next frame's target byte can
   // be taken during the write pulse; the done flag follows one cycle later.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (target) state_nxt = HDR_LO;
         HDR_LO:     if (rx_vld_i) state_nxt = HDR_HI;
         HDR_HI: begin
            if (rx_vld_i) begin
               if (count == 16'd0)                 state_nxt = DONE;
               else if (32'(count) > 32'(DEPTH))   state_nxt = IDLE;
               else                                state_nxt = DATA;
            end
         end
         DATA:       if (word_end && (rem == 16'd1)) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (expire) state_nxt = IDLE;
   end

   always_ff @(posedge upg_clk_i) begin
      if (upg_rst_i) begin
         state      <= IDLE;
         upg_wen_o  <= 1'b0;
         upg_sel_o  <= 1'b0;
         upg_adr_o  <= '0;
         upg_dat_o  <= '0;
         upg_done_o <= 1'b0;
         upg_err_o  <= 1'b0;
         cnt_lo     <= '0;
         rem        <= '0;
         bidx       <= '0;
         part       <= '0;
         tcnt       <= '0;
      end else begin
         state     <= state_nxt;
         upg_wen_o <= word_end;
         tcnt      <= (rx_vld_i || !in_frame) ? '0 : tcnt + TW'(1);
         if (upg_wen_o) upg_adr_o <= upg_adr_o + ADDR_W'(1);
         if (expire) begin
            upg_err_o <= 1'b1;
            bidx      <= '0;
         end
         case (state)
            IDLE, DONE: begin
               if (target) begin
                  upg_sel_o  <= rx_dat_i[0];
                  upg_done_o <= 1'b0;
                  upg_err_o  <= 1'b0;
                  upg_adr_o  <= '0;
                  bidx       <= '0;
               end else if (state == DONE) begin
                  upg_done_o <= 1'b1;
               end
            end
            HDR_LO: if (rx_vld_i) cnt_lo <= rx_dat_i;
            HDR_HI: begin
               if (rx_vld_i) begin
                  rem <= count;
                  if (count == 16'd0)               upg_done_o <= 1'b1;
                  else if (32'(count) > 32'(DEPTH)) upg_err_o  <= 1'b1;
               end
            end
            DATA: begin
               if (rx_vld_i) begin
                  bidx <= bidx + 2'd1;
                  case (bidx)
                     2'd0:    part[7:0]   <= rx_dat_i;
                     2'd1:    part[15:8]  <= rx_dat_i;
                     2'd2:    part[23:16] <= rx_dat_i;
                     default: begin
                        upg_dat_o <= {rx_dat_i, part};
                        rem       <= rem - 16'd1;
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: directed frames plus randomized frame streams
// compared against a frame-level parser model.
`timescale 1ns/1ps
module tb_uart_word_loader;
   localparam int ADDR_W  = 14;
   localparam int DEPTH   = 16384;
   localparam int TIMEOUT = 20;

   typedef logic [7:0]        u8_t;
   typedef logic [ADDR_W+32:0] wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        rx_dat = 8'h00;
   logic              rx_vld = 1'b0;
   logic              wen, sel, done, err, busy;
   logic [ADDR_W-1:0] adr;
   logic [31:0]       dat;

   int  chk  = 0;
   int  fail = 0;
   wr_t got_q[$];
   wr_t exp_q[$];
   logic m_sel, m_done, m_err;

   uart_word_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .upg_clk_i (clk),
      .upg_rst_i (rst),
      .rx_dat_i  (rx_dat),
      .rx_vld_i  (rx_vld),
      .upg_wen_o (wen),
      .upg_sel_o (sel),
      .upg_adr_o (adr),
      .upg_dat_o (dat),
      .upg_done_o(done),
      .upg_err_o (err),
      .busy_o    (busy)
   );

   always #50 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && wen) begin
         got_q.push_back({sel, adr, dat});
         chk++;
         if (done !== 1'b0) begin
            fail++;
            $display("FAIL wen_done_overlap: done=%b during wen, required 0", done);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input u8_t b, input int gap);
      rx_dat = b;
      rx_vld = 1'b1;
      tick(1);
      rx_vld = 1'b0;
      rx_dat = u8_t'($urandom);
      tick(gap);
   endtask

   task automatic send_q(input u8_t bs[$], input int maxgap);
      foreach (bs[i]) send(bs[i], $urandom_range(0, maxgap));
   endtask

   // Frame-level parser: walks the byte list and lists the writes it implies.
   task automatic model_run(input u8_t bs[$]);
      int i;
      int cnt;
      i = 0;
      while (i < bs.size()) begin
         if (bs[i] > 8'd1) begin
            i++;
         end else begin
            m_sel  = bs[i][0];
            m_done = 1'b0;
            m_err  = 1'b0;
            i++;
            if (i + 1 >= bs.size()) break;
            cnt = int'({bs[i+1], bs[i]});
            i += 2;
            if (cnt == 0) m_done = 1'b1;
            else if (cnt > DEPTH) m_err = 1'b1;
            else begin
               for (int w = 0; w < cnt; w++) begin
                  if (i + 3 < bs.size())
                     exp_q.push_back({m_sel, ADDR_W'(w), bs[i+3], bs[i+2], bs[i+1], bs[i]});
                  i += 4;
               end
               m_done = 1'b1;
            end
         end
      end
   endtask

   function automatic int wr_diff();
      int n;
      n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic wr_t q_at(input wr_t q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : '0;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      chk++;
      if ({wen, sel, done, err, busy, adr, dat} !== '0) begin
         fail++;
         $display("FAIL reset_outputs: wen=%b sel=%b done=%b err=%b busy=%b adr=%h dat=%h, required all 0",
                  wen, sel, done, err, busy, adr, dat);
      end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_basic();
      u8_t bs[$];
      int idx;
      bs = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      model_run(bs);
      for (int i = 0; i < 10; i++) send(bs[i], 0);
      send(bs[10], 0);
      chk++;
      if ({wen, sel, adr, dat, done} !== {1'b1, 1'b1, ADDR_W'(1), 32'hDEADBEEF, 1'b0}) begin
         fail++;
         $display("FAIL basic_pulse2: wen=%b sel=%b adr=%h dat=%h done=%b, required 1 1 1 deadbeef 0",
                  wen, sel, adr, dat, done);
      end
      tick(1);
      chk++;
      if ({wen, done, busy, err} !== 4'b0100) begin
         fail++;
         $display("FAIL basic_done: wen=%b done=%b busy=%b err=%b, required 0 1 0 0", wen, done, busy, err);
      end
      tick(3);
      idx = wr_diff();
      chk++;
      if (idx >= 0) begin
         fail++;
         $display("FAIL basic_writes: entry %0d got %h (n=%0d) required %h (n=%0d)",
                  idx, q_at(got_q, idx), got_q.size(), q_at(exp_q, idx), exp_q.size());
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_zero();
      send(8'h00, 1);
      send(8'h00, 2);
      send(8'h00, 0);
      chk++;
      if ({done, sel, err, busy} !== 4'b1000) begin
         fail++;
         $display("FAIL zero_count: done=%b sel=%b err=%b busy=%b, required 1 0 0 0", done, sel, err, busy);
      end
      tick(3);
      chk++;
      if (got_q.size() != 0) begin
         fail++;
         $display("FAIL zero_writes: %0d writes, required 0", got_q.size());
      end
      got_q.delete();
   endtask

   task automatic test_overflow();
      u8_t bs[$];
      int idx;
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'h40, 0);
      chk++;
      if ({err, done, busy} !== 3'b100) begin
         fail++;
         $display("FAIL overflow_err: err=%b done=%b busy=%b, required 1 0 0", err, done, busy);
      end
      send(8'h00, 0);
      chk++;
      if ({err, busy} !== 2'b01) begin
         fail++;
         $display("FAIL overflow_clear: err=%b busy=%b, required 0 1", err, busy);
      end
      bs = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_q(bs, 2);
      tick(3);
      exp_q.push_back({1'b0, ADDR_W'(0), 32'hDDCCBBAA});
      idx = wr_diff();
      chk++;
      if (idx >= 0 || done !== 1'b1) begin
         fail++;
         $display("FAIL overflow_next: entry %0d got %h (n=%0d) required %h (n=%0d), done=%b required 1",
                  idx, q_at(got_q, idx), got_q.size(), q_at(exp_q, idx), exp_q.size(), done);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_timeout();
      u8_t bs[$];
      int idx;
      bs = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22};
      foreach (bs[i]) send(bs[i], 0);
      tick(TIMEOUT - 1);
      chk++;
      if ({err, busy} !== 2'b01) begin
         fail++;
         $display("FAIL timeout_early: err=%b busy=%b after %0d idle cycles, required 0 1", err, busy, TIMEOUT - 1);
      end
      tick(1);
      chk++;
      if ({err, busy, done} !== 3'b100) begin
         fail++;
         $display("FAIL timeout_fire: err=%b busy=%b done=%b, required 1 0 0", err, busy, done);
      end
      tick(3);
      chk++;
      if (got_q.size() != 0) begin
         fail++;
         $display("FAIL timeout_nowrite: %0d writes, required 0", got_q.size());
      end
      got_q.delete();
      foreach (bs[i]) send(bs[i], 0);
      tick(TIMEOUT - 1);
      send(8'h33, 0);
      chk++;
      if ({err, busy} !== 2'b01) begin
         fail++;
         $display("FAIL timeout_limit_strobe: err=%b busy=%b, required 0 1", err, busy);
      end
      send(8'h44, 0);
      tick(3);
      exp_q.push_back({1'b1, ADDR_W'(0), 32'h44332211});
      idx = wr_diff();
      chk++;
      if (idx >= 0 || err !== 1'b0 || done !== 1'b1) begin
         fail++;
         $display("FAIL timeout_resume: entry %0d got %h (n=%0d) required %h (n=%0d), err=%b done=%b required 0 1",
                  idx, q_at(got_q, idx), got_q.size(), q_at(exp_q, idx), exp_q.size(), err, done);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      u8_t bs[$];
      int idx;
      bs = '{8'h01, 8'h03, 8'h00};
      for (int i = 0; i < 12; i++) bs.push_back(u8_t'($urandom));
      bs.push_back(8'h00);
      bs.push_back(8'h00);
      bs.push_back(8'h00);
      model_run(bs);
      foreach (bs[i]) send(bs[i], 0);
      tick(3);
      idx = wr_diff();
      chk++;
      if (idx >= 0) begin
         fail++;
         $display("FAIL b2b_writes: entry %0d got %h (n=%0d) required %h (n=%0d)",
                  idx, q_at(got_q, idx), got_q.size(), q_at(exp_q, idx), exp_q.size());
      end
      chk++;
      if ({sel, done, err, busy} !== {m_sel, m_done, m_err, 1'b0}) begin
         fail++;
         $display("FAIL b2b_flags: sel=%b done=%b err=%b busy=%b, required %b %b %b 0",
                  sel, done, err, busy, m_sel, m_done, m_err);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      u8_t bs[$];
      int idx;
      int kind;
      int cnt;
      for (int f = 0; f < 10; f++) begin
         kind = $urandom_range(0, 5);
         cnt  = (kind == 5) ? DEPTH + 1 + $urandom_range(0, 3000) : kind;
         if ($urandom_range(0, 2) == 0) bs.push_back(u8_t'($urandom_range(2, 255)));
         bs.push_back(u8_t'($urandom_range(0, 1)));
         bs.push_back(u8_t'(cnt));
         bs.push_back(u8_t'(cnt >> 8));
         if (kind != 5)
            for (int w = 0; w < cnt * 4; w++) bs.push_back(u8_t'($urandom));
      end
      model_run(bs);
      send_q(bs, 3);
      tick(4);
      idx = wr_diff();
      chk++;
      if (idx >= 0) begin
         fail++;
         $display("FAIL random_writes: entry %0d got %h (n=%0d) required %h (n=%0d)",
                  idx, q_at(got_q, idx), got_q.size(), q_at(exp_q, idx), exp_q.size());
      end
      chk++;
      if ({sel, done, err, busy} !== {m_sel, m_done, m_err, 1'b0}) begin
         fail++;
         $display("FAIL random_flags: sel=%b done=%b err=%b busy=%b, required %b %b %b 0",
                  sel, done, err, busy, m_sel, m_done, m_err);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      u8_t bs[$];
      int idx;
      bs = '{8'h01, 8'h02, 8'h00, 8'hAA, 8'hBB};
      foreach (bs[i]) send(bs[i], 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk++;
      if ({wen, sel, done, err, busy, adr, dat} !== '0) begin
         fail++;
         $display("FAIL reset_mid: wen=%b sel=%b done=%b err=%b busy=%b adr=%h dat=%h, required all 0",
                  wen, sel, done, err, busy, adr, dat);
      end
      send(8'h55, 2);
      chk++;
      if ({busy, err, done} !== 3'b000) begin
         fail++;
         $display("FAIL stray_byte: busy=%b err=%b done=%b, required 0 0 0", busy, err, done);
      end
      bs = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      model_run(bs);
      send_q(bs, 1);
      tick(3);
      idx = wr_diff();
      chk++;
      if (idx >= 0 || done !== 1'b1) begin
         fail++;
         $display("FAIL reset_restart: entry %0d got %h (n=%0d) required %h (n=%0d), done=%b required 1",
                  idx, q_at(got_q, idx), got_q.size(), q_at(exp_q, idx), exp_q.size(), done);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
      $finish;
   end
endmodule
